hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 117 +++++++++++
 tb/tb_hazard_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard controller: data-hazard and mult/div stall detection with a flush override and an md-unit busy tracker.
// Latency: enables, DE_clear and md_busy are combinational in the current cycle; md_cnt and stall_cnt update on posedge clk.
// Backpressure: a stall holds PC and F/D and puts a nop into E; Req overrides the stall. Optional macro HAZARD_STALL_PERF_EN adds the stall counter.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic [4:0]  D_rs_addr,
    input  logic [4:0]  D_rt_addr,
    input  logic [1:0]  D_rs_tuse,
    input  logic [1:0]  D_rt_tuse,
    input  logic [4:0]  E_write_addr,
    input  logic [4:0]  M_write_addr,
    input  logic [1:0]  E_tnew,
    input  logic [1:0]  M_tnew,
    input  logic        D_is_md,
    input  logic        E_md_start,
    input  logic        E_md_div,
    output logic        PC_en,
    output logic        FD_en,
    output logic        DE_en,
    output logic        DE_clear,
    output logic        md_busy,
    output logic [31:0] stall_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_t;

    localparam logic [3:0] MULT_CYCLES = 4'd5;
    localparam logic [3:0] DIV_CYCLES  = 4'd10;

    logic [3:0] r_md_cnt;
    logic [3:0] w_md_cnt_nxt;
    md_state_t  w_md_state;
    logic       w_rs_stall;
    logic       w_rt_stall;
    logic       w_data_stall;
    logic       w_md_stall;
    logic       w_stall;

    // Operand hazards: a producer in E or M whose result arrives later than the operand is needed.
    // tuse == 3 marks an unused operand and can never stall.
    always_comb begin
        w_rs_stall = (D_rs_addr != 5'd0) && (D_rs_tuse != 2'd3) &&
                     (((D_rs_addr == E_write_addr) && (E_tnew > D_rs_tuse)) ||
                      ((D_rs_addr == M_write_addr) && (M_tnew > D_rs_tuse)));
        w_rt_stall = (D_rt_addr != 5'd0) && (D_rt_tuse != 2'd3) &&
                     (((D_rt_addr == E_write_addr) && (E_tnew > D_rt_tuse)) ||
                      ((D_rt_addr == M_write_addr) && (M_tnew > D_rt_tuse)));
        w_data_stall = w_rs_stall || w_rt_stall;
        w_md_stall   = D_is_md && (md_busy || E_md_start);
        w_stall      = w_data_stall || w_md_stall;
    end

    // md unit next-state: IDLE loads on an uncancelled start, BUSY counts down to zero and ignores new starts.
    always_comb begin
        w_md_cnt_nxt = r_md_cnt;
        w_md_state   = (r_md_cnt != 4'd0) ? BUSY : IDLE;
        case (w_md_state)
            IDLE: begin
                if (E_md_start && !Req) begin
                    w_md_cnt_nxt = E_md_div ? DIV_CYCLES : MULT_CYCLES;
                end
            end
            BUSY: begin
                w_md_cnt_nxt = r_md_cnt - 4'd1;
            end
            default: begin
                w_md_cnt_nxt = 4'd0;
            end
        endcase
    end

    // md counter register; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_md_cnt <= 4'd0;
        end else begin
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // Pipeline enables: reset and Req both release the pipeline, otherwise a stall freezes PC/FD and bubbles E.
    always_comb begin
        PC_en    = 1'b1;
        FD_en    = 1'b1;
        DE_en    = 1'b1;
        DE_clear = 1'b0;
        md_busy  = reset && (w_md_state == BUSY);
        if (reset && !Req && w_stall) begin
            PC_en    = 1'b0;
            FD_en    = 1'b0;
            DE_clear = 1'b1;
        end
    end

`ifdef HAZARD_STALL_PERF_EN
    logic [31:0] r_stall_cnt;

    // Stall-cycle performance counter; cycles overridden by Req are not counted, wraps naturally.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && !Req) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: vector table for single-cycle hazard cases plus hand-built multi-cycle md/reset sequences.
// Expected results are queued when a cycle is driven and popped on the following negedge.
// Handles builds with or without HAZARD_STALL_PERF_EN.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset, Req;
    logic [4:0]  D_rs_addr, D_rt_addr, E_write_addr, M_write_addr;
    logic [1:0]  D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic        D_is_md, E_md_start, E_md_div;
    logic        PC_en, FD_en, DE_en, DE_clear, md_busy;
    logic [31:0] stall_cnt;

    hazard_ctrl dut (
        .clk(clk), .reset(reset), .Req(Req),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse),
        .E_write_addr(E_write_addr), .M_write_addr(M_write_addr),
        .E_tnew(E_tnew), .M_tnew(M_tnew),
        .D_is_md(D_is_md), .E_md_start(E_md_start), .E_md_div(E_md_div),
        .PC_en(PC_en), .FD_en(FD_en), .DE_en(DE_en), .DE_clear(DE_clear),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       req;
        logic [4:0] rs, rt, ewa, mwa;
        logic [1:0] rs_tu, rt_tu, etn, mtn;
        logic       is_md, start, div;
        logic       x_stall;
        logic       x_busy;
    } vec_t;

    typedef struct {
        logic        pc, fd, de, clr, busy;
        logic [31:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 32'd0;

    function automatic vec_t v_idle();
        vec_t v;
        v.rst = 1'b1; v.req = 1'b0;
        v.rs = 5'd0; v.rt = 5'd0; v.ewa = 5'd0; v.mwa = 5'd0;
        v.rs_tu = 2'd3; v.rt_tu = 2'd3; v.etn = 2'd0; v.mtn = 2'd0;
        v.is_md = 1'b0; v.start = 1'b0; v.div = 1'b0;
        v.x_stall = 1'b0; v.x_busy = 1'b0;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, compare at the negedge, then advance past the posedge.
    task automatic step(input vec_t v, input string tag);
        exp_t e, g;
        logic frz;
        reset = v.rst; Req = v.req;
        D_rs_addr = v.rs; D_rt_addr = v.rt; E_write_addr = v.ewa; M_write_addr = v.mwa;
        D_rs_tuse = v.rs_tu; D_rt_tuse = v.rt_tu; E_tnew = v.etn; M_tnew = v.mtn;
        D_is_md = v.is_md; E_md_start = v.start; E_md_div = v.div;
        frz = v.rst && !v.req && v.x_stall;
        e.pc = !frz; e.fd = !frz; e.de = 1'b1; e.clr = frz;
        e.busy = v.rst && v.x_busy;
        e.cnt = model_cnt;
        exp_q.push_back(e);
`ifdef HAZARD_STALL_PERF_EN
        if (!v.rst) model_cnt = 32'd0;
        else if (v.x_stall && !v.req) model_cnt = model_cnt + 32'd1;
`endif
        @(negedge clk);
        g = exp_q.pop_front();
        chk({tag, ".PC_en"}, {31'd0, PC_en}, {31'd0, g.pc});
        chk({tag, ".FD_en"}, {31'd0, FD_en}, {31'd0, g.fd});
        chk({tag, ".DE_en"}, {31'd0, DE_en}, {31'd0, g.de});
        chk({tag, ".DE_clear"}, {31'd0, DE_clear}, {31'd0, g.clr});
        chk({tag, ".md_busy"}, {31'd0, md_busy}, {31'd0, g.busy});
        chk({tag, ".stall_cnt"}, stall_cnt, g.cnt);
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[12];
    vec_t v;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Vector table, md unit idle throughout.
        for (int i = 0; i < 12; i++) tbl[i] = v_idle();
        tbl[1].rs = 5'd8; tbl[1].ewa = 5'd8; tbl[1].etn = 2'd2; tbl[1].rs_tu = 2'd1; tbl[1].x_stall = 1'b1;
        tbl[2].rs = 5'd8; tbl[2].ewa = 5'd8; tbl[2].etn = 2'd1; tbl[2].rs_tu = 2'd1;
        tbl[3].rs = 5'd0; tbl[3].ewa = 5'd0; tbl[3].etn = 2'd2; tbl[3].rs_tu = 2'd0;
        tbl[4].rt = 5'd9; tbl[4].ewa = 5'd9; tbl[4].etn = 2'd2; tbl[4].rt_tu = 2'd3;
        tbl[5].rt = 5'd9; tbl[5].mwa = 5'd9; tbl[5].mtn = 2'd1; tbl[5].rt_tu = 2'd0; tbl[5].x_stall = 1'b1;
        tbl[6].rt = 5'd9; tbl[6].mwa = 5'd9; tbl[6].mtn = 2'd1; tbl[6].rt_tu = 2'd1;
        tbl[7].rs = 5'd8; tbl[7].ewa = 5'd8; tbl[7].etn = 2'd2; tbl[7].rs_tu = 2'd0; tbl[7].req = 1'b1; tbl[7].x_stall = 1'b1;
        tbl[8].rs = 5'd5; tbl[8].ewa = 5'd6; tbl[8].etn = 2'd2; tbl[8].rs_tu = 2'd0;
        tbl[9].is_md = 1'b1;
        tbl[10].rs = 5'd7; tbl[10].mwa = 5'd7; tbl[10].mtn = 2'd2; tbl[10].rs_tu = 2'd3;
        tbl[11].rt = 5'd31; tbl[11].ewa = 5'd31; tbl[11].etn = 2'd3; tbl[11].rt_tu = 2'd2; tbl[11].x_stall = 1'b1;

        // Unchecked first reset cycle clears all state.
        v = v_idle(); v.rst = 1'b0;
        reset = 1'b0; Req = 1'b0;
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; E_write_addr = 5'd0; M_write_addr = 5'd0;
        D_rs_tuse = 2'd3; D_rt_tuse = 2'd3; E_tnew = 2'd0; M_tnew = 2'd0;
        D_is_md = 1'b0; E_md_start = 1'b0; E_md_div = 1'b0;
        @(posedge clk); #1;

        // Reset forces the enables even with a live hazard present.
        v = tbl[1]; v.rst = 1'b0;
        step(v, "reset_hazard");
        step(v_idle(), "post_reset");

        // Seven stall cycles, one of them overridden by Req.
        for (int i = 0; i < 7; i++) begin
            v = tbl[1]; v.req = (i == 3);
            step(v, $sformatf("perf%0d", i));
        end
        @(negedge clk);
`ifdef HAZARD_STALL_PERF_EN
        chk("stall_cnt_7", stall_cnt, 32'd6);
`else
        chk("stall_cnt_7", stall_cnt, 32'd0);
`endif
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) step(tbl[i], $sformatf("tbl%0d", i));

        // E_tnew=2 stall drops the following cycle once E_tnew=1.
        step(tbl[1], "e_tnew2");
        step(tbl[2], "e_tnew1");

        // mult: busy cycles 1-5, D_is_md stalls cycles 0-5.
        for (int c = 0; c <= 6; c++) begin
            v = v_idle(); v.is_md = 1'b1;
            v.start = (c == 0); v.div = 1'b0;
            v.x_busy = (c >= 1 && c <= 5);
            v.x_stall = (c <= 5);
            step(v, $sformatf("mult_c%0d", c));
        end

        // div with Req at cycle 3 and an ignored restart at cycle 5: busy cycles 1-10.
        for (int c = 0; c <= 11; c++) begin
            v = v_idle();
            v.start = (c == 0) || (c == 5); v.div = 1'b1;
            v.req = (c == 3);
            v.x_busy = (c >= 1 && c <= 10);
            step(v, $sformatf("div_req_c%0d", c));
        end

        // start cancelled by Req in the same cycle never loads.
        v = v_idle(); v.start = 1'b1; v.div = 1'b1; v.req = 1'b1;
        step(v, "cancel_c0");
        step(v_idle(), "cancel_c1");
        step(v_idle(), "cancel_c2");

        // reset during cycle 4 of a div aborts it.
        for (int c = 0; c <= 5; c++) begin
            v = v_idle();
            v.start = (c == 0); v.div = 1'b1;
            v.rst = (c != 4);
            v.x_busy = (c >= 1 && c <= 3);
            step(v, $sformatf("div_rst_c%0d", c));
        end
        @(negedge clk);
        chk("stall_cnt_after_reset", stall_cnt, 32'd0);
        chk("md_busy_after_reset", {31'd0, md_busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
